spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
- Parametrised SPI slave: the next generation of the team's fixed 8-bit, mode-0 SPI slave.
- Adds configurable word width, all four CPOL/CPHA modes and MSB/LSB-first ordering.
- Adds a valid/ready TX holding register with underrun flag, partial-word abort detection and a MISO output-enable.
- Sits between the external SPI pins and the on-chip register/command logic, fully synchronous to the fast system clock.

Parameters:
- DATA_W, 8, word length in bits (2..32).
- CPOL, 0, idle level of SCK.
- CPHA, 0, 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- MSB_FIRST, 1, 1 = MSB transmitted/received first; 0 = LSB first.
- IDLE_FILL, 0, bit value driven on MISO after an underrun.

Ports:
- clk  in  1  system clock; must be at least 4x SCK.
- rst_n  in  1  reset; asynchronous, active-low.
- sck  in  1  SPI clock, asynchronous.
- ssel_n  in  1  chip select, active-low, asynchronous.
- mosi  in  1  master out, asynchronous.
- miso  out  1  slave out.
- miso_oe  out  1  1 while the slave is selected.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_abort  out  1  one-cycle pulse when ssel_n deasserts mid-word.
- tx_data  in  DATA_W  next word to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty.
- tx_underrun  out  1  one-cycle pulse when a word starts with the holding register empty.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): all synchronisers load idle values (sck = CPOL, ssel_n = 1, mosi = 0).
  - FSM enters IDLE.
  - miso = 0, miso_oe = 0, rx_data = 0, rx_valid = rx_abort = tx_underrun = 0.
  - tx_ready = 1, busy = 0, bit counter = 0, holding register empty.
- Synchronisation: sck and ssel_n use 3-flop chains; edges are detected on stages [2:1]. mosi uses 2 flops. Edge-to-action latency is 3 clk.
- Edge mapping: the leading edge is the SCK transition away from CPOL. The sample edge is the leading edge if CPHA=0, otherwise the trailing edge. The shift edge is the other one.
- FSM states:
  - IDLE: wait for the ssel_n falling edge, then go to LOAD.
  - LOAD (1 cycle):
    - Load the shift register from the holding register if full (tx_ready -> 1); otherwise load all IDLE_FILL and pulse tx_underrun.
    - If CPHA=0, the first bit is on miso before the first SCK edge.
    - Go to ACTIVE.
  - ACTIVE:
    - On each sample edge: shift in mosi (direction per MSB_FIRST) and increment the counter.
    - When the counter reaches DATA_W-1 on a sample edge: the next cycle updates rx_data, pulses rx_valid and wraps the counter to 0.
    - On each shift edge: present the next tx bit.
    - CPHA=0: the shift edge following the final sample reloads a new word, with the same rules as LOAD, instead of shifting. CPHA=1: the first shift edge of each word (counter==0) reloads, then drives bit 0.
  - Any state except IDLE: an ssel_n rising edge returns the FSM to IDLE. If the counter is nonzero, the partial word is discarded and rx_abort pulses; rx_data is unchanged.
- TX handshake:
  - The holding register accepts on tx_valid && tx_ready; tx_ready drops the next cycle.
  - A load on the same cycle as a reload is accepted and used by that reload.
  - The holding register is not cleared by deselect.
- miso_oe = (state != IDLE). miso = current shift-register output bit, or 0 when not selected.
- Simultaneous events: ssel_n deassertion takes priority over any same-cycle SCK edge. An SCK edge while in IDLE is ignored.
- No RX backpressure: rx_data is overwritten on the next word.

Decomposition:
- Package spi_pkg holds:
  - the typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} spi_state_t;
  - the constants SCK_SYNC_STAGES = 3 and MOSI_SYNC_STAGES = 2;
  - a function computing the sample/shift edge selection from CPOL/CPHA.
- One sub-module, spi_edge_sync: parametrised stage count, reset value, rise/fall outputs. It is instantiated for sck and ssel_n; mosi uses a plain synchroniser with no edge detect.

Test Plan:
- Mode 0, DATA_W=8, MSB first: preload tx 0xA5, master sends 0x3C -> rx_valid once with rx_data=0x3C; master receives 0xA5.
- Mode 3, DATA_W=16, LSB first: tx 0x1234, master sends 0xBEEF -> rx_data=0xBEEF; master receives 0x1234 with correct bit order.
- Back-to-back 2 words in mode 1, tx 0x11 then 0x22 written after the first tx_ready -> rx_valid x2; master sees 0x11, 0x22; no underrun.
- No tx preload, mode 0, IDLE_FILL=1 -> tx_underrun pulse in LOAD; master receives 0xFF.
- ssel_n raised after 5 of 8 bits -> rx_abort pulse, rx_data unchanged, FSM IDLE; next full transfer of 0x81 received correctly.
- rst_n asserted mid-word (async, between clk edges) -> outputs immediately at reset values; after release a full transfer of 0x5A succeeds.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the parametrised SPI slave.
//   spi_state_t      : FSM state encoding (IDLE, LOAD, ACTIVE)
//   SCK_SYNC_STAGES  : synchroniser depth for sck and ssel_n
//   MOSI_SYNC_STAGES : synchroniser depth for mosi
//   edge_select()    : maps CPOL/CPHA onto which SCK edge samples and shifts
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } spi_state_t;

    localparam int SCK_SYNC_STAGES  = 3;
    localparam int MOSI_SYNC_STAGES = 2;

    typedef struct packed {
        logic sample_on_rise;
        logic shift_on_rise;
    } spi_edge_sel_t;

    // The leading edge is the transition away from CPOL, so it is a rising
    // edge when CPOL=0. Sampling happens on the leading edge only when
    // CPHA=0, which makes "sample on rise" equivalent to CPOL == CPHA.
    function automatic spi_edge_sel_t edge_select(input logic cpol, input logic cpha);
        spi_edge_sel_t sel;
        sel.sample_on_rise = (cpol == cpha);
        sel.shift_on_rise  = (cpol != cpha);
        return sel;
    endfunction

endpackage

// File: rtl/spi_slave_param_edge_sync.sv
// -----------------------------------------------------------------------------
// spi_edge_sync
// Multi-flop synchroniser for an asynchronous pin with edge detection on the
// two oldest stages.
//   clk, rst_n : system clock, async active-low reset (loads RESET_VAL)
//   d_i        : asynchronous input
//   rise_o     : one-cycle pulse on a synchronised 0->1 transition
//   fall_o     : one-cycle pulse on a synchronised 1->0 transition
// STAGES must be at least 3 so the edge detector never looks at the
// metastability-exposed first flop.
// -----------------------------------------------------------------------------
module spi_edge_sync #(
    parameter int   STAGES    = 3,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; stage 0 captures the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign rise_o = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall_o = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_param.sv
// -----------------------------------------------------------------------------
// spi_slave_param
// SPI slave with configurable word width, CPOL/CPHA mode, bit order and a
// valid/ready TX holding register. Everything runs on clk (>= 4x SCK).
//   clk, rst_n        : system clock, async active-low reset
//   sck_i, ssel_n_i,
//   mosi_i            : asynchronous SPI pins
//   miso_o, miso_oe_o : slave data out and its output enable (selected)
//   rx_data_o         : last complete received word
//   rx_valid_o        : one-cycle pulse when rx_data_o updates
//   rx_abort_o        : one-cycle pulse when deselected mid-word
//   tx_data_i,
//   tx_valid_i,
//   tx_ready_o        : holding-register write handshake (ready = empty)
//   tx_underrun_o     : one-cycle pulse when a word starts with nothing held
//   busy_o            : FSM is not in IDLE
// -----------------------------------------------------------------------------
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1,
    parameter int IDLE_FILL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck_i,
    input  logic              ssel_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              rx_abort_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_underrun_o,
    output logic              busy_o
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam spi_edge_sel_t    EDGE_SEL = edge_select(CPOL != 0, CPHA != 0);
    localparam logic             SCK_IDLE = (CPOL != 0);
    localparam logic             FILL_BIT = (IDLE_FILL != 0);

    // Bit currently presented on MISO for a given shift-register value.
    function automatic logic tx_out_bit(input logic [DATA_W-1:0] sh);
        if (MSB_FIRST != 0) begin
            return sh[DATA_W-1];
        end else begin
            return sh[0];
        end
    endfunction

    // ---------------- synchronisers ----------------
    logic sck_rise_s, sck_fall_s, ssel_rise_s, ssel_fall_s, mosi_s;
    logic sample_edge_s, shift_edge_s;
    logic [MOSI_SYNC_STAGES-1:0] mosi_sync_q;

    spi_edge_sync #(.STAGES(SCK_SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sck_i),
        .rise_o (sck_rise_s),
        .fall_o (sck_fall_s)
    );

    spi_edge_sync #(.STAGES(SCK_SYNC_STAGES), .RESET_VAL(1'b1)) u_ssel_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (ssel_n_i),
        .rise_o (ssel_rise_s),
        .fall_o (ssel_fall_s)
    );

    // Plain level synchroniser for mosi; it is only read on sample edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[MOSI_SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign mosi_s        = mosi_sync_q[MOSI_SYNC_STAGES-1];
    assign sample_edge_s = EDGE_SEL.sample_on_rise ? sck_rise_s : sck_fall_s;
    assign shift_edge_s  = EDGE_SEL.shift_on_rise  ? sck_rise_s : sck_fall_s;

    // ---------------- state and datapath registers ----------------
    spi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_abort_q, rx_abort_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] rx_next_s;
    logic [DATA_W-1:0] tx_shifted_s;
    logic [DATA_W-1:0] reload_word_s;
    logic              reload_fill_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; deselect wins over any same-cycle SCK edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ssel_fall_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD, ACTIVE: begin
                if (ssel_rise_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift helpers in the configured bit order.
    always_comb begin
        if (MSB_FIRST != 0) begin
            rx_next_s    = {rx_sh_q[DATA_W-2:0], mosi_s};
            tx_shifted_s = {tx_sh_q[DATA_W-2:0], 1'b0};
        end else begin
            rx_next_s    = {mosi_s, rx_sh_q[DATA_W-1:1]};
            tx_shifted_s = {1'b0, tx_sh_q[DATA_W-1:1]};
        end
    end

    // Word for a load/reload: the held word, a same-cycle write, or fill.
    always_comb begin
        reload_fill_s = 1'b0;
        if (!tx_ready_q) begin
            reload_word_s = hold_q;
        end else if (tx_valid_i) begin
            reload_word_s = tx_data_i;
        end else begin
            reload_word_s = {DATA_W{FILL_BIT}};
            reload_fill_s = 1'b1;
        end
    end

    // FSM outputs and datapath next values.
    always_comb begin
        cnt_d         = cnt_q;
        wrap_d        = wrap_q;
        rx_sh_d       = rx_sh_q;
        tx_sh_d       = tx_sh_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_abort_d    = 1'b0;
        tx_underrun_d = 1'b0;

        // Holding-register write; a reload below may consume it again.
        if (tx_valid_i && tx_ready_q) begin
            hold_d     = tx_data_i;
            tx_ready_d = 1'b0;
        end else begin
            hold_d     = hold_q;
            tx_ready_d = tx_ready_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                wrap_d = 1'b0;
            end
            LOAD: begin
                cnt_d  = '0;
                wrap_d = 1'b0;
                if (ssel_rise_s) begin
                    tx_sh_d = tx_sh_q;
                end else begin
                    tx_sh_d       = reload_word_s;
                    tx_underrun_d = reload_fill_s;
                    tx_ready_d    = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssel_rise_s) begin
                    // Partial word is dropped; rx_data keeps the last full word.
                    rx_abort_d = (cnt_q != '0);
                    cnt_d      = '0;
                    wrap_d     = 1'b0;
                end else if (sample_edge_s) begin
                    rx_sh_d = rx_next_s;
                    if (cnt_q == LAST_CNT) begin
                        rx_data_d  = rx_next_s;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        wrap_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge_s) begin
                    // wrap_q marks that a full word has just been sampled, so
                    // this shift edge starts the next word. With CPHA=1 the very
                    // first shift edge after LOAD only presents bit 0, which the
                    // load already put on the line.
                    if (cnt_q != '0) begin
                        tx_sh_d = tx_shifted_s;
                    end else if (wrap_q) begin
                        tx_sh_d       = reload_word_s;
                        tx_underrun_d = reload_fill_s;
                        tx_ready_d    = 1'b1;
                        wrap_d        = 1'b0;
                    end else begin
                        tx_sh_d = tx_sh_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d  = '0;
                wrap_d = 1'b0;
            end
        endcase

        // Pin-facing outputs are registered from next-state values so they
        // line up with state_q rather than lagging it by a cycle.
        miso_oe_d = (state_d != IDLE);
        busy_d    = (state_d != IDLE);
        if (state_d != IDLE) begin
            miso_d = tx_out_bit(tx_sh_d);
        end else begin
            miso_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            wrap_q        <= 1'b0;
            rx_sh_q       <= '0;
            tx_sh_q       <= '0;
            hold_q        <= '0;
            tx_ready_q    <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_abort_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            wrap_q        <= wrap_d;
            rx_sh_q       <= rx_sh_d;
            tx_sh_q       <= tx_sh_d;
            hold_q        <= hold_d;
            tx_ready_q    <= tx_ready_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_abort_q    <= rx_abort_d;
            tx_underrun_q <= tx_underrun_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            busy_q        <= busy_d;
        end
    end

    assign miso_o        = miso_q;
    assign miso_oe_o     = miso_oe_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_abort_o    = rx_abort_q;
    assign tx_ready_o    = tx_ready_q;
    assign tx_underrun_o = tx_underrun_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// -----------------------------------------------------------------------------
// Bench for spi_slave_param. Three instances cover the parameter sets:
//   inst 0: mode 0, 8 bit, MSB first, IDLE_FILL=1
//   inst 1: mode 1, 8 bit, MSB first
//   inst 2: mode 3, 16 bit, LSB first
// Expected RX words go into per-instance queues; monitors pop them on rx_valid.
// -----------------------------------------------------------------------------
module tb_spi_slave_param;

    localparam time HALF = 80ns;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] sck_v  = 3'b100;
    logic [2:0] ssel_v = 3'b111;
    logic [2:0] mosi_v = 3'b000;
    logic [2:0] txv_v  = 3'b000;
    logic [7:0]  txd0 = '0;
    logic [7:0]  txd1 = '0;
    logic [15:0] txd2 = '0;
    wire  [2:0] miso_v, oe_v, rxv_v, abort_v, ready_v, urun_v, busy_v;
    wire  [7:0]  rx0, rx1;
    wire  [15:0] rx2;

    int n_chk = 0;
    int n_fail = 0;
    int abort_cnt[3] = '{0, 0, 0};
    int urun_cnt[3]  = '{0, 0, 0};
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    always #5ns clk = ~clk;

    spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .IDLE_FILL(1)) u0 (
        .clk(clk), .rst_n(rst_n), .sck_i(sck_v[0]), .ssel_n_i(ssel_v[0]), .mosi_i(mosi_v[0]),
        .miso_o(miso_v[0]), .miso_oe_o(oe_v[0]), .rx_data_o(rx0), .rx_valid_o(rxv_v[0]),
        .rx_abort_o(abort_v[0]), .tx_data_i(txd0), .tx_valid_i(txv_v[0]), .tx_ready_o(ready_v[0]),
        .tx_underrun_o(urun_v[0]), .busy_o(busy_v[0]));

    spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .IDLE_FILL(0)) u1 (
        .clk(clk), .rst_n(rst_n), .sck_i(sck_v[1]), .ssel_n_i(ssel_v[1]), .mosi_i(mosi_v[1]),
        .miso_o(miso_v[1]), .miso_oe_o(oe_v[1]), .rx_data_o(rx1), .rx_valid_o(rxv_v[1]),
        .rx_abort_o(abort_v[1]), .tx_data_i(txd1), .tx_valid_i(txv_v[1]), .tx_ready_o(ready_v[1]),
        .tx_underrun_o(urun_v[1]), .busy_o(busy_v[1]));

    spi_slave_param #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .IDLE_FILL(0)) u2 (
        .clk(clk), .rst_n(rst_n), .sck_i(sck_v[2]), .ssel_n_i(ssel_v[2]), .mosi_i(mosi_v[2]),
        .miso_o(miso_v[2]), .miso_oe_o(oe_v[2]), .rx_data_o(rx2), .rx_valid_o(rxv_v[2]),
        .rx_abort_o(abort_v[2]), .tx_data_i(txd2), .tx_valid_i(txv_v[2]), .tx_ready_o(ready_v[2]),
        .tx_underrun_o(urun_v[2]), .busy_o(busy_v[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: unexpected rx_valid with 0x%0h at %0t", name, act, $time);
        end else begin
            check(name, act, q.pop_front());
        end
    endtask

    // Scoreboard monitors: pop expected words on rx_valid, count pulses.
    always @(negedge clk) begin
        if (rxv_v[0]) pop_check("rx0", 32'(rx0), q0);
        if (rxv_v[1]) pop_check("rx1", 32'(rx1), q1);
        if (rxv_v[2]) pop_check("rx2", 32'(rx2), q2);
        for (int m = 0; m < 3; m++) begin
            if (abort_v[m]) abort_cnt[m]++;
            if (urun_v[m])  urun_cnt[m]++;
        end
    end

    // Write one word into instance i's holding register.
    task automatic tx_push(input int i, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!ready_v[i] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", 32'(ready_v[i]), 32'd1);
        case (i)
            0: txd0 = d[7:0];
            1: txd1 = d[7:0];
            default: txd2 = d[15:0];
        endcase
        txv_v[i] = 1'b1;
        @(negedge clk);
        txv_v[i] = 1'b0;
        check("tx_ready_drop", 32'(ready_v[i]), 32'd0);
    endtask

    // Master side of nbits bit-times of one word.
    task automatic spi_word(input int i, input int width, input logic cpol, input logic cpha,
                            input logic msb, input logic [31:0] tx_word, input int nbits,
                            output logic [31:0] rx_word);
        rx_word = '0;
        for (int k = 0; k < nbits; k++) begin
            int b;
            b = msb ? (width - 1 - k) : k;
            if (!cpha) begin
                mosi_v[i] = tx_word[b];
                #HALF;
                sck_v[i] = ~cpol;
                rx_word[b] = miso_v[i];
                #HALF;
                sck_v[i] = cpol;
            end else begin
                sck_v[i] = ~cpol;
                mosi_v[i] = tx_word[b];
                #HALF;
                sck_v[i] = cpol;
                rx_word[b] = miso_v[i];
                #HALF;
            end
        end
    endtask

    task automatic select(input int i);
        ssel_v[i] = 1'b0;
        #HALF;
    endtask

    task automatic deselect(input int i);
        #HALF;
        ssel_v[i] = 1'b1;
        #(4 * HALF);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int base_u, base_a;
        int n;

        // Reset state.
        #23ns;
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 32'(ready_v[i]), 32'd1);
            check("rst_busy",  32'(busy_v[i]),  32'd0);
            check("rst_oe",    32'(oe_v[i]),    32'd0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Mode 0: preload 0xA5, master sends 0x3C.
        tx_push(0, 32'hA5);
        q0.push_back(32'h3C);
        base_u = urun_cnt[0];
        select(0);
        check("m0_busy", 32'(busy_v[0]), 32'd1);
        check("m0_oe",   32'(oe_v[0]),   32'd1);
        check("m0_no_urun_load", 32'(urun_cnt[0] - base_u), 32'd0);
        spi_word(0, 8, 1'b0, 1'b0, 1'b1, 32'h3C, 8, got);
        check("m0_miso", got, 32'hA5);
        deselect(0);
        // The trailing edge after the last sample reloads from an empty holding register.
        check("m0_urun_end", 32'(urun_cnt[0] - base_u), 32'd1);
        check("m0_idle_oe", 32'(oe_v[0]), 32'd0);

        // Mode 3, 16 bit, LSB first.
        tx_push(2, 32'h1234);
        q2.push_back(32'hBEEF);
        base_u = urun_cnt[2];
        select(2);
        spi_word(2, 16, 1'b1, 1'b1, 1'b0, 32'hBEEF, 16, got);
        check("m3_miso", got, 32'h1234);
        deselect(2);
        check("m3_urun", 32'(urun_cnt[2] - base_u), 32'd0);

        // Mode 1, two words back to back; second tx written once ready returns.
        tx_push(1, 32'h11);
        q1.push_back(32'hC5);
        q1.push_back(32'h7E);
        base_u = urun_cnt[1];
        fork
            begin
                logic [31:0] g1;
                select(1);
                spi_word(1, 8, 1'b0, 1'b1, 1'b1, 32'hC5, 8, g1);
                check("m1_miso_w1", g1, 32'h11);
                spi_word(1, 8, 1'b0, 1'b1, 1'b1, 32'h7E, 8, g1);
                check("m1_miso_w2", g1, 32'h22);
                deselect(1);
            end
            begin
                n = 0;
                while (!ready_v[1] && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                tx_push(1, 32'h22);
            end
        join
        check("m1_urun", 32'(urun_cnt[1] - base_u), 32'd0);

        // Underrun: no preload, IDLE_FILL=1.
        q0.push_back(32'h96);
        base_u = urun_cnt[0];
        select(0);
        check("ur_load_pulse", 32'(urun_cnt[0] - base_u), 32'd1);
        spi_word(0, 8, 1'b0, 1'b0, 1'b1, 32'h96, 8, got);
        check("ur_miso", got, 32'hFF);
        deselect(0);
        check("ur_total", 32'(urun_cnt[0] - base_u), 32'd2);

        // Abort after 5 of 8 bits.
        base_a = abort_cnt[0];
        select(0);
        spi_word(0, 8, 1'b0, 1'b0, 1'b1, 32'hF0, 5, got);
        deselect(0);
        check("ab_pulse", 32'(abort_cnt[0] - base_a), 32'd1);
        check("ab_rx_keep", 32'(rx0), 32'h96);
        check("ab_idle", 32'(busy_v[0]), 32'd0);
        check("ab_miso0", 32'(miso_v[0]), 32'd0);
        tx_push(0, 32'h3E);
        q0.push_back(32'h81);
        select(0);
        spi_word(0, 8, 1'b0, 1'b0, 1'b1, 32'h81, 8, got);
        check("ab_next_miso", got, 32'h3E);
        deselect(0);
        check("ab_no_extra", 32'(abort_cnt[0] - base_a), 32'd1);

        // Asynchronous reset mid-word.
        select(0);
        spi_word(0, 8, 1'b0, 1'b0, 1'b1, 32'hAA, 4, got);
        @(posedge clk);
        #2ns;
        rst_n = 1'b0;
        #1ns;
        check("ar_miso",  32'(miso_v[0]), 32'd0);
        check("ar_oe",    32'(oe_v[0]),   32'd0);
        check("ar_rx",    32'(rx0),       32'd0);
        check("ar_busy",  32'(busy_v[0]), 32'd0);
        check("ar_ready", 32'(ready_v[0]), 32'd1);
        check("ar_rxv",   32'(rxv_v[0]),  32'd0);
        ssel_v[0] = 1'b1;
        mosi_v[0] = 1'b0;
        #47ns;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        base_a = abort_cnt[0];
        tx_push(0, 32'hC3);
        q0.push_back(32'h5A);
        select(0);
        spi_word(0, 8, 1'b0, 1'b0, 1'b1, 32'h5A, 8, got);
        check("ar_next_miso", got, 32'hC3);
        deselect(0);
        check("ar_no_abort", 32'(abort_cnt[0] - base_a), 32'd0);

        // Every expected word must have been delivered.
        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);
        check("q2_empty", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
